// File: rtl/pool_2_if.sv
// ---------------------------------------------------------------------------
// pool_2_if : bundle of every signal the 2x2 max-pool stage exchanges with the
// outside world except clock and reset.
//
// Signals
//   pool_2_en        level enable, a rising edge starts a pass
//   pool_2_finish    sticky "pass complete" flag
//   fm_bram_1_*      two read ports (a/b) into the conv-2 feature map
//   fm_bram_2_*      single write port into the pooled feature map
//
// Modports
//   master : the pooling engine (drives BRAM controls, reads BRAM data)
//   slave  : the environment (memories plus whoever drives the enable)
// ---------------------------------------------------------------------------
interface pool_2_if #(
    parameter int LANES  = 56,
    parameter int DW     = 16,
    parameter int AW_IN  = 7,
    parameter int AW_OUT = 5
);

    logic                   pool_2_en;
    logic                   pool_2_finish;

    logic                   fm_bram_1_ena;
    logic                   fm_bram_1_enb;
    logic [AW_IN-1:0]       fm_bram_1_addra;
    logic [AW_IN-1:0]       fm_bram_1_addrb;
    logic [LANES*DW-1:0]    fm_bram_1_douta;
    logic [LANES*DW-1:0]    fm_bram_1_doutb;

    logic                   fm_bram_2_wea;
    logic [AW_OUT-1:0]      fm_bram_2_addra;
    logic [LANES*DW-1:0]    fm_bram_2_dina;

    modport master (
        input  pool_2_en,
        input  fm_bram_1_douta,
        input  fm_bram_1_doutb,
        output pool_2_finish,
        output fm_bram_1_ena,
        output fm_bram_1_enb,
        output fm_bram_1_addra,
        output fm_bram_1_addrb,
        output fm_bram_2_wea,
        output fm_bram_2_addra,
        output fm_bram_2_dina
    );

    modport slave (
        output pool_2_en,
        output fm_bram_1_douta,
        output fm_bram_1_doutb,
        input  pool_2_finish,
        input  fm_bram_1_ena,
        input  fm_bram_1_enb,
        input  fm_bram_1_addra,
        input  fm_bram_1_addrb,
        input  fm_bram_2_wea,
        input  fm_bram_2_addra,
        input  fm_bram_2_dina
    );

endinterface

// File: rtl/pool_2.sv
// ---------------------------------------------------------------------------
// pool_2 : 2x2 stride-2 max-pool stage after the second convolution.
//
// Reads the IN_W x IN_W conv-2 map (one BRAM word = one spatial position,
// LANES lanes of DW-bit two's complement, CH of them active) through two read
// ports, one row of the window per port, and writes the pooled
// (IN_W/2) x (IN_W/2) map one word per output position.
//
// Ports
//   clk   clock
//   rst   synchronous active-high reset
//   bus   pool_2_if.master: pool_2_en / pool_2_finish handshake,
//         fm_bram_1 read ports a/b, fm_bram_2 write port
//
// Build option
//   POOL_2_RELU_EN  when defined, negative pooled lanes are written as 0;
//                   timing and addressing are identical in both builds.
// ---------------------------------------------------------------------------
module pool_2 #(
    parameter int RD_LAT = 2,
    parameter int CH     = 50,
    parameter int LANES  = 56,
    parameter int DW     = 16,
    parameter int IN_W   = 8,
    parameter int AW_IN  = 7,
    parameter int AW_OUT = 5
) (
    input  logic        clk,
    input  logic        rst,
    pool_2_if.master    bus
);

    localparam int OUT_W = IN_W / 2;
    localparam int N_OUT = OUT_W * OUT_W;
    localparam int OW    = $clog2(N_OUT);
    localparam int TW    = OW + 1;
    localparam int DCW   = $clog2(RD_LAT + 1) + 1;
    localparam int WW    = LANES * DW;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic               en_dly_q, en_dly_d;
    logic [OW-1:0]      o_q, o_d;
    logic               k_q, k_d;
    logic [DCW-1:0]     drain_q, drain_d;
    logic [RD_LAT-1:0]  vld_q, vld_d;
    logic [TW-1:0]      tag_q [RD_LAT];
    logic [TW-1:0]      tag_d [RD_LAT];
    logic [WW-1:0]      vmax_q, vmax_d;
    logic [WW-1:0]      dina_q, dina_d;
    logic [AW_OUT-1:0]  waddr_q, waddr_d;
    logic               wea_q, wea_d;

    logic               en_p;
    logic               flush;
    logic               issue;
    logic               rd_active;
    logic [AW_IN-1:0]   rd_base;
    logic               out_vld;
    logic [TW-1:0]      out_tag;
    logic [WW-1:0]      pair_max;
    logic [WW-1:0]      pooled;
    logic               unused_pad;

    // Padding lanes of the read data carry nothing useful.
    assign unused_pad = ^{bus.fm_bram_1_douta[WW-1:CH*DW], bus.fm_bram_1_doutb[WW-1:CH*DW]};

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return ($signed(x) > $signed(y)) ? x : y;
    endfunction

    // Control FSM. flush discards every tag in flight, so an abort or restart
    // can never produce a stale write; issue marks a beat whose data we keep.
    always_comb begin
        en_p     = bus.pool_2_en & ~en_dly_q;
        en_dly_d = bus.pool_2_en;
        state_d  = state_q;
        o_d      = o_q;
        k_d      = k_q;
        drain_d  = drain_q;
        flush    = 1'b0;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_p) begin
                    state_d = READ;
                    o_d     = '0;
                    k_d     = 1'b0;
                end
            end
            READ, DRAIN: begin
                if (!bus.pool_2_en) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                    o_d     = '0;
                    k_d     = 1'b0;
                end else if (en_p) begin
                    state_d = READ;
                    flush   = 1'b1;
                    o_d     = '0;
                    k_d     = 1'b0;
                end else if (state_q == READ) begin
                    issue = 1'b1;
                    k_d   = ~k_q;
                    if (k_q) begin
                        if (o_q == OW'(N_OUT - 1)) begin
                            state_d = DRAIN;
                            drain_d = '0;
                            o_d     = '0;
                        end else begin
                            o_d = o_q + OW'(1);
                        end
                    end
                end else if (drain_q == DCW'(RD_LAT)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            DONE: begin
                if (en_p) begin
                    state_d = READ;
                    o_d     = '0;
                    k_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window addressing: port a reads the top row of the 2x2 window, port b
    // the row below; k selects the left or right column.
    always_comb begin
        rd_active = (state_q == READ);
        rd_base   = AW_IN'((2 * IN_W) * (int'(o_q) / OUT_W) + 2 * (int'(o_q) % OUT_W) + int'(k_q));
    end

    assign bus.fm_bram_1_ena   = rd_active;
    assign bus.fm_bram_1_enb   = rd_active;
    assign bus.fm_bram_1_addra = rd_active ? rd_base : '0;
    assign bus.fm_bram_1_addrb = rd_active ? rd_base + AW_IN'(IN_W) : '0;

    // Lane-wise signed max: pair_max folds one column of the window, pooled
    // folds the second column into the first. Padding lanes stay zero.
    always_comb begin
        pair_max = '0;
        pooled   = '0;
        for (int i = 0; i < CH; i++) begin
            pair_max[i*DW +: DW] = smax(bus.fm_bram_1_douta[i*DW +: DW], bus.fm_bram_1_doutb[i*DW +: DW]);
            pooled[i*DW +: DW]   = smax(vmax_q[i*DW +: DW], pair_max[i*DW +: DW]);
`ifdef POOL_2_RELU_EN
            if (pooled[i*DW + DW - 1]) begin
                pooled[i*DW +: DW] = '0;
            end
`endif
        end
    end

    // Tag pipeline matching the BRAM read latency; the tail of the pipe lines
    // up with the data returning on douta/doutb.
    always_comb begin
        vld_d    = '0;
        tag_d    = tag_q;
        vld_d[0] = issue;
        tag_d[0] = {o_q, k_q};
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
        if (flush) begin
            vld_d = '0;
        end
        out_vld = vld_q[RD_LAT-1] & ~flush;
        out_tag = tag_q[RD_LAT-1];
        vmax_d  = vmax_q;
        dina_d  = dina_q;
        waddr_d = waddr_q;
        wea_d   = 1'b0;
        if (out_vld) begin
            if (!out_tag[0]) begin
                vmax_d = pair_max;
            end else begin
                dina_d  = pooled;
                waddr_d = AW_OUT'(out_tag[TW-1:1]);
                wea_d   = 1'b1;
            end
        end
    end

    assign bus.fm_bram_2_wea   = wea_q;
    assign bus.fm_bram_2_addra = waddr_q;
    assign bus.fm_bram_2_dina  = dina_q;
    assign bus.pool_2_finish   = (state_q == DONE);

    // State register; reset clears the FSM, the tag pipe and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            en_dly_q <= 1'b0;
            o_q      <= '0;
            k_q      <= 1'b0;
            drain_q  <= '0;
            vld_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
            vmax_q   <= '0;
            dina_q   <= '0;
            waddr_q  <= '0;
            wea_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_dly_q <= en_dly_d;
            o_q      <= o_d;
            k_q      <= k_d;
            drain_q  <= drain_d;
            vld_q    <= vld_d;
            tag_q    <= tag_d;
            vmax_q   <= vmax_d;
            dina_q   <= dina_d;
            waddr_q  <= waddr_d;
            wea_q    <= wea_d;
        end
    end

endmodule

// File: tb/tb_pool_2.sv
// ---------------------------------------------------------------------------
// tb_pool_2 : bench for pool_2. Three copies of the design run side by side
// with read latencies 1, 2 and 3, each behind its own BRAM model reading a
// shared feature-map array, all driven by the same enable and reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pool_2;

    localparam int CH     = 50;
    localparam int LANES  = 56;
    localparam int DW     = 16;
    localparam int IN_W   = 8;
    localparam int AW_IN  = 7;
    localparam int AW_OUT = 5;
    localparam int WW     = LANES * DW;
    localparam int NLAT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic clr = 1'b0;
    int   cyc = 0;

    logic [WW-1:0]     mem [128];

    logic [NLAT-1:0]   ena_v, enb_v, wea_v, fin_v;
    logic [AW_IN-1:0]  addra_v [NLAT];
    logic [AW_IN-1:0]  addrb_v [NLAT];
    logic [AW_OUT-1:0] waddr_v [NLAT];
    logic [WW-1:0]     dina_v  [NLAT];

    int              wr_cnt    [NLAT];
    int              ord_err   [NLAT];
    int              issue_cyc [NLAT];
    int              wea_cyc   [NLAT];
    int              fin_cyc   [NLAT];
    logic [NLAT-1:0] fin_prev;
    logic [WW-1:0]   cap [NLAT][16];

    int nChecks = 0;
    int nErrors = 0;

    // Free-running clock and a cycle counter used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // One DUT per read latency, each with a BRAM model whose data appears
    // RD_LAT cycles after the address is registered.
    for (genvar g = 0; g < NLAT; g++) begin : lat_gen
        localparam int LAT = g + 1;
        logic [WW-1:0] pa [LAT];
        logic [WW-1:0] pb [LAT];

        pool_2_if #(.LANES(LANES), .DW(DW), .AW_IN(AW_IN), .AW_OUT(AW_OUT)) bus ();

        pool_2 #(
            .RD_LAT(LAT), .CH(CH), .LANES(LANES), .DW(DW),
            .IN_W(IN_W), .AW_IN(AW_IN), .AW_OUT(AW_OUT)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        always @(posedge clk) begin
            if (bus.fm_bram_1_ena) pa[0] <= mem[bus.fm_bram_1_addra];
            if (bus.fm_bram_1_enb) pb[0] <= mem[bus.fm_bram_1_addrb];
            for (int i = 1; i < LAT; i++) begin
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
        end

        assign bus.fm_bram_1_douta = pa[LAT-1];
        assign bus.fm_bram_1_doutb = pb[LAT-1];
        assign bus.pool_2_en       = en;
        assign ena_v[g]   = bus.fm_bram_1_ena;
        assign enb_v[g]   = bus.fm_bram_1_enb;
        assign addra_v[g] = bus.fm_bram_1_addra;
        assign addrb_v[g] = bus.fm_bram_1_addrb;
        assign wea_v[g]   = bus.fm_bram_2_wea;
        assign waddr_v[g] = bus.fm_bram_2_addra;
        assign dina_v[g]  = bus.fm_bram_2_dina;
        assign fin_v[g]   = bus.pool_2_finish;
    end

    // Write monitor on the falling edge: stores each written word, counts
    // writes, flags out-of-order addresses and timestamps the last read beat,
    // the last write and the rise of finish. rst or clr wipes the record.
    always @(negedge clk) begin
        for (int g = 0; g < NLAT; g++) begin
            if (rst || clr) begin
                wr_cnt[g]    <= 0;
                ord_err[g]   <= 0;
                issue_cyc[g] <= -100;
                wea_cyc[g]   <= -200;
                fin_cyc[g]   <= -300;
                fin_prev[g]  <= 1'b0;
                for (int j = 0; j < 16; j++) cap[g][j] <= '0;
            end else begin
                if (ena_v[g] && addra_v[g] == AW_IN'(55)) issue_cyc[g] <= cyc;
                if (wea_v[g]) begin
                    if (int'(waddr_v[g]) != wr_cnt[g]) ord_err[g] <= ord_err[g] + 1;
                    cap[g][waddr_v[g][3:0]] <= dina_v[g];
                    wr_cnt[g]  <= wr_cnt[g] + 1;
                    wea_cyc[g] <= cyc;
                end
                if (fin_v[g] && !fin_prev[g]) fin_cyc[g] <= cyc;
                fin_prev[g] <= fin_v[g];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Expected pooled lane for each data pattern (0 ramp, 1 signed, 2 max position).
    function automatic logic [15:0] expLane(input int kind, input int o, input int i);
        int r;
        int c;
        r = o / 4;
        c = o % 4;
        if (i >= CH) return 16'h0000;
        case (kind)
            0: return 16'(((2 * r + 1) * 8 + 2 * c + 1) * 4 + i);
`ifdef POOL_2_RELU_EN
            1: return 16'h0000;
`else
            1: return 16'hFFFF;
`endif
            default: return 16'(1000 + o * 16 + i);
        endcase
    endfunction

    task automatic fillMem(input int kind);
        logic [15:0] sv [4];
        logic [15:0] v;
        int y, x, slot, o;
        sv[0] = 16'hFFFB;
        sv[1] = 16'hFED4;
        sv[2] = 16'h8000;
        sv[3] = 16'hFFFF;
        for (int a = 0; a < 128; a++) mem[a] = '0;
        for (int a = 0; a < 64; a++) begin
            y    = a / 8;
            x    = a % 8;
            slot = (y % 2) * 2 + (x % 2);
            o    = (y / 2) * 4 + x / 2;
            for (int i = 0; i < LANES; i++) begin
                case (kind)
                    0:       v = 16'(a * 4 + i);
                    1:       v = sv[slot];
                    default: v = (slot == o % 4) ? 16'(1000 + o * 16 + i) : 16'(-2000 + a * 3 + i);
                endcase
                mem[a][i*DW +: DW] = v;
            end
        end
    endtask

    // Load a pattern, reset, raise pool_2_en and let the pass run out.
    task automatic applyStimulus(input int kind);
        fillMem(kind);
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        en = 1'b1;
        tick(70);
    endtask

    // Reset, start a pass and stop in the READ cycle of beat 10.
    task automatic startToBeat10(input int kind);
        fillMem(kind);
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        en = 1'b1;
        tick(11);
    endtask

    task automatic checkPass(input int kind, input string name);
        for (int g = 0; g < NLAT; g++) begin
            checkOutput($sformatf("%s lat%0d write count", name, g + 1), wr_cnt[g], 16);
            checkOutput($sformatf("%s lat%0d address order", name, g + 1), ord_err[g], 0);
            checkOutput($sformatf("%s lat%0d finish", name, g + 1), {31'd0, fin_v[g]}, 1);
            checkOutput($sformatf("%s lat%0d ena idle", name, g + 1), {31'd0, ena_v[g]}, 0);
            checkOutput($sformatf("%s lat%0d beat-to-wea", name, g + 1), wea_cyc[g] - issue_cyc[g], g + 2);
            checkOutput($sformatf("%s lat%0d wea-to-finish", name, g + 1), fin_cyc[g] - wea_cyc[g], 1);
            for (int o = 0; o < 16; o++) begin
                for (int i = 0; i < LANES; i++) begin
                    checkOutput($sformatf("%s lat%0d o%0d lane%0d", name, g + 1, o, i),
                                {16'h0, cap[g][o][i*DW +: DW]}, {16'h0, expLane(kind, o, i)});
                end
            end
        end
    endtask

    task automatic checkQuiet(input string name);
        for (int g = 0; g < NLAT; g++) begin
            checkOutput($sformatf("%s lat%0d ena", name, g + 1), {31'd0, ena_v[g]}, 0);
            checkOutput($sformatf("%s lat%0d enb", name, g + 1), {31'd0, enb_v[g]}, 0);
            checkOutput($sformatf("%s lat%0d addra", name, g + 1), 32'(addra_v[g]), 0);
            checkOutput($sformatf("%s lat%0d addrb", name, g + 1), 32'(addrb_v[g]), 0);
            checkOutput($sformatf("%s lat%0d wea", name, g + 1), {31'd0, wea_v[g]}, 0);
            checkOutput($sformatf("%s lat%0d waddr", name, g + 1), 32'(waddr_v[g]), 0);
            checkOutput($sformatf("%s lat%0d dina nonzero", name, g + 1), {31'd0, |dina_v[g]}, 0);
            checkOutput($sformatf("%s lat%0d finish", name, g + 1), {31'd0, fin_v[g]}, 0);
        end
    endtask

    // Test sequence.
    initial begin
        fillMem(0);
        tick(2);
        checkQuiet("reset");
        rst = 1'b0;

        applyStimulus(0);
        checkPass(0, "ramp");

        applyStimulus(1);
        checkPass(1, "signed");

        applyStimulus(2);
        checkPass(2, "maxpos");

        startToBeat10(0);
        rst = 1'b1;
        en  = 1'b0;
        tick(1);
        checkQuiet("rst_mid");
        rst = 1'b0;
        tick(40);
        for (int g = 0; g < NLAT; g++) begin
            checkOutput($sformatf("rst_mid lat%0d writes after reset", g + 1), wr_cnt[g], 0);
            checkOutput($sformatf("rst_mid lat%0d finish", g + 1), {31'd0, fin_v[g]}, 0);
        end
        applyStimulus(0);
        checkPass(0, "after_rst");

        startToBeat10(0);
        en  = 1'b0;
        clr = 1'b1;
        tick(1);
        en  = 1'b1;
        clr = 1'b0;
        tick(70);
        checkPass(0, "restart");

        startToBeat10(2);
        en  = 1'b0;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(40);
        for (int g = 0; g < NLAT; g++) begin
            checkOutput($sformatf("abort lat%0d writes", g + 1), wr_cnt[g], 0);
            checkOutput($sformatf("abort lat%0d finish", g + 1), {31'd0, fin_v[g]}, 0);
            checkOutput($sformatf("abort lat%0d ena", g + 1), {31'd0, ena_v[g]}, 0);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/pool_2.md
Name: pool_2

Overview:
- 2x2 stride-2 max-pool stage directly downstream of the second convolution stage.
- Reads the 8x8x50 conv-2 output map from fm_bram_1 over two read ports and writes the 4x4x50 pooled map to fm_bram_2.
- Each BRAM word is one spatial position holding all channels: LANES x DW bits, lane i = channel i, two's complement.
- Started by a rising edge of pool_2_en; reports completion on pool_2_finish.

Parameters:
- RD_LAT, 2, fm_bram_1 read latency in cycles (address/enable registered to dout valid).
- CH, 50, active channels per word.
- LANES, 56, lanes per word (lanes CH..LANES-1 are padding).
- DW, 16, bits per lane.
- IN_W, 8, input map width and height.
- AW_IN, 7, fm_bram_1 address width.
- AW_OUT, 5, fm_bram_2 address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pool_2_en  in  1  level enable; rising edge starts a pass.
- fm_bram_1_ena  out  1  read enable, port a.
- fm_bram_1_enb  out  1  read enable, port b.
- fm_bram_1_addra  out  AW_IN  read address, port a.
- fm_bram_1_addrb  out  AW_IN  read address, port b.
- fm_bram_1_douta  in  LANES*DW  read data, port a.
- fm_bram_1_doutb  in  LANES*DW  read data, port b.
- fm_bram_2_wea  out  1  write enable.
- fm_bram_2_addra  out  AW_OUT  write address.
- fm_bram_2_dina  out  LANES*DW  write data.
- pool_2_finish  out  1  pass complete, sticky.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous, active-high.
  - On rst, every output is 0, the FSM goes to IDLE, and the valid pipeline is cleared.
- Rising-edge detect: pool_2_en_p = pool_2_en & ~pool_2_en_d, with pool_2_en_d registered.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ on pool_2_en_p.
  - READ issues 32 read beats, one per cycle. Output index o = 0..15, r = o/4, c = o%4, beat k = 0,1:
    - addra = 2r*IN_W + 2c + k
    - addrb = (2r+1)*IN_W + 2c + k
    - ena = enb = 1 during every READ cycle, 0 otherwise.
    - Counters: k toggles each beat; o increments after k = 1.
  - READ -> DRAIN after beat (o=15, k=1).
  - DRAIN waits RD_LAT+1 cycles for in-flight data, then -> DONE.
  - DONE holds pool_2_finish = 1 until rst or pool_2_en_p; pool_2_en_p restarts at READ with finish cleared.
- Datapath: the tag {o, k} travels through an RD_LAT-deep valid/tag shift register.
  - Data returning for k=0: vmax <= lane-wise signed max(douta, doutb).
  - Data returning for k=1: fm_bram_2_dina <= lane-wise signed max(vmax, douta, doutb); fm_bram_2_addra <= o; fm_bram_2_wea <= 1.
  - Lanes CH..LANES-1 of dina are always 0.
  - wea is a one-cycle pulse per output: 16 pulses per pass, addresses 0..15 ascending.
- Latency: the second beat of output o is issued in cycle t; wea for o is high in cycle t+RD_LAT+1.
- Last write to finish: pool_2_finish rises the cycle after the last wea pulse.
- Ties: equal values pass unchanged; max of -32768 with itself = -32768.
- pool_2_en low in READ/DRAIN: abort to IDLE, clear the valid pipeline, suppress further writes, finish stays 0.
- pool_2_en_p in READ/DRAIN: restart from o=0, k=0; in-flight tags are flushed.
- rst asserted mid-pass: same as reset; no write after the reset cycle.

Optional Feature:
- Macro: POOL_2_RELU_EN.
- Defined: each active lane of dina = max(pooled, 0), i.e. a negative result (sign bit set) is written as 0.
- Undefined: raw signed max is written, negatives preserved.
- Latency, addressing and handshake are identical in both builds.

Test Plan:
- Ramp data:
  - Stimulus: word at address a holds lane i = a*4+i; rising edge on pool_2_en, RD_LAT=2.
  - Required: 16 wea pulses at addresses 0..15; output o lane i = ((2r+1)*8+2c+1)*4+i (e.g. o=0 lane 0 = 36); finish high one cycle after the last write.
- Signed compare:
  - Stimulus: window {-5, -300, -32768, -1}, all lanes.
  - Required: without POOL_2_RELU_EN, -1 (0xFFFF); with it, 0.
- Max position:
  - Stimulus: the maximum is placed in each of the four window slots in turn.
  - Required: it is always selected; padding lanes 50..55 are 0.
- Reset mid-pass:
  - Stimulus: rst asserted at beat 10 for 1 cycle.
  - Required: all outputs 0 next cycle; no further wea; a fresh pool_2_en edge runs a full correct pass.
- Restart and abort:
  - Stimulus: second pool_2_en rising edge mid-READ.
  - Required: addresses restart at 0, exactly 16 writes follow the restart.
  - Stimulus: pool_2_en dropped mid-READ.
  - Required: IDLE, no further writes, finish stays 0.
- Latency sweep:
  - Stimulus: RD_LAT = 1 and RD_LAT = 3.
  - Required: results identical to RD_LAT=2; wea timing = RD_LAT+1 cycles after the second beat.
